// File: rtl/clock_gen_multi.sv
// Per-channel divided square waves with glitch-free start/stop, plus a sequenced active-low reset.
// clk_out/tick/ch_active are registered one edge after the deciding sample; there is no backpressure.
module clock_gen_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int RST_HOLD = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int RC_W    = $clog2(RST_HOLD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_start,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] ch_active,
    output logic              resetn_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} ch_state_t;

    logic [CNT_W-1:0] wr_half;
    assign wr_half = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] half_act_q, half_act_d;
        logic [CNT_W-1:0] half_pend_q, half_pend_d;
        logic [CNT_W-1:0] phase_q, phase_d;
        logic [CNT_W-1:0] start_cnt;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr;
        logic             at_end;

        assign wr        = cfg_we && (cfg_ch == CH_W'(i));
        assign start_cnt = (phase_q < half_act_q) ? phase_q : '0;
        assign at_end    = (cnt_q == half_act_q - CNT_W'(1));

        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            half_act_d  = half_act_q;
            half_pend_d = half_pend_q;
            phase_d     = phase_q;
            clk_d       = clk_q;
            tick_d      = 1'b0;

            if (wr) begin
                half_pend_d = wr_half;
                phase_d     = cfg_phase;
            end

            case (state_q)
                S_IDLE: begin
                    clk_d = 1'b0;
                    if (ch_en[i]) begin
                        state_d = S_RUN;
                        cnt_d   = start_cnt;
                    end
                end
                default: begin
                    if (sync_start) begin
                        cnt_d   = start_cnt;
                        clk_d   = 1'b0;
                        state_d = ch_en[i] ? S_RUN : S_IDLE;
                    end else begin
                        if (at_end) begin
                            clk_d      = ~clk_q;
                            tick_d     = ~clk_q;
                            cnt_d      = '0;
                            half_act_d = half_pend_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        // Stop only while low, or on the falling toggle itself.
                        if (ch_en[i]) begin
                            state_d = S_RUN;
                        end else if (!clk_q || at_end) begin
                            state_d = S_IDLE;
                            clk_d   = 1'b0;
                            tick_d  = 1'b0;
                        end else begin
                            state_d = S_STOP;
                        end
                    end
                end
            endcase

            // An idle channel always runs with its most recent programmed half-period.
            if (state_d == S_IDLE) begin
                half_act_d = half_pend_d;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= S_IDLE;
                cnt_q       <= '0;
                half_act_q  <= CNT_W'(1);
                half_pend_q <= CNT_W'(1);
                phase_q     <= '0;
                clk_q       <= 1'b0;
                tick_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                half_act_q  <= half_act_d;
                half_pend_q <= half_pend_d;
                phase_q     <= phase_d;
                clk_q       <= clk_d;
                tick_q      <= tick_d;
            end
        end

        assign clk_out[i]   = clk_q;
        assign tick[i]      = tick_q;
        assign ch_active[i] = (state_q != S_IDLE);
    end

    logic [RC_W-1:0] rst_cnt;
    logic            resetn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt  <= '0;
            resetn_q <= 1'b0;
        end else if (rst_cnt == RC_W'(RST_HOLD)) begin
            resetn_q <= 1'b1;
        end else begin
            rst_cnt <= rst_cnt + 1'b1;
        end
    end

    assign resetn_out = resetn_q;

endmodule
